// File: rtl/dm_store_controller_if.sv
// rtl/dm_store_controller_if.sv - request and data-memory signal bundle for the store controller
interface dm_store_controller_if #(
  parameter int ADDR_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [1:0]        i_size;
  logic [63:0]       i_wdata;
  logic              o_ready;
  logic              o_done;
  logic              o_miss_aligned_error;
  logic [ADDR_W-1:0] o_dm_addr;
  logic              o_dm_rd;
  logic [63:0]       i_dm_rdata;
  logic              o_dm_wr;
  logic [63:0]       o_dm_wdata;

  modport slave (
    input  i_req, i_addr, i_size, i_wdata, i_dm_rdata,
    output o_ready, o_done, o_miss_aligned_error, o_dm_addr, o_dm_rd, o_dm_wr, o_dm_wdata
  );

  modport master (
    output i_req, i_addr, i_size, i_wdata, i_dm_rdata,
    input  o_ready, o_done, o_miss_aligned_error, o_dm_addr, o_dm_rd, o_dm_wr, o_dm_wdata
  );
endinterface

// File: rtl/dm_store_controller.sv
// rtl/dm_store_controller.sv - MEM-stage store path with read-modify-write for sub-doubleword stores
module dm_store_controller #(
  parameter int ADDR_W = 32
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  dm_store_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_MERGE,
    S_WRITE,
    S_ERR
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic [2:0]        r_off;
  logic [63:0]       r_wdata;
  logic [63:0]       r_merged;

  logic              w_legal;
  logic [7:0]        w_mask;
  logic [63:0]       w_sized;
  logic [63:0]       w_aligned;
  logic [63:0]       w_merged;
  logic              w_ready;
  logic              w_done;
  logic              w_err;
  logic              w_rd;
  logic              w_wr;

  // Natural-alignment check of the incoming request against its own size
  always_comb begin
    w_legal = 1'b0;
    case (bus.i_size)
      2'b00:   w_legal = 1'b1;
      2'b01:   w_legal = ~bus.i_addr[0];
      2'b10:   w_legal = (bus.i_addr[1:0] == 2'b00);
      default: w_legal = (bus.i_addr[2:0] == 3'b000);
    endcase
  end

  // Byte-lane mask and lane-aligned store data for the latched request
  always_comb begin
    w_mask  = 8'hFF;
    w_sized = r_wdata;
    case (r_size)
      2'b00: begin
        w_mask  = 8'h01 << r_off;
        w_sized = {56'd0, r_wdata[7:0]};
      end
      2'b01: begin
        w_mask  = 8'h03 << r_off;
        w_sized = {48'd0, r_wdata[15:0]};
      end
      2'b10: begin
        w_mask  = 8'h0F << r_off;
        w_sized = {32'd0, r_wdata[31:0]};
      end
      default: begin
        w_mask  = 8'hFF;
        w_sized = r_wdata;
      end
    endcase
    w_aligned = w_sized << {r_off, 3'b000};
  end

  // Per-lane merge: new bytes where the mask is set, memory bytes elsewhere
  always_comb begin
    w_merged = bus.i_dm_rdata;
    for (int i = 0; i < 8; i++) begin
      if (w_mask[i]) w_merged[i*8 +: 8] = w_aligned[i*8 +: 8];
    end
  end

  // State register; reset abandons any store in flight
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state selection and the one-cycle strobes of each state
  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_done  = 1'b0;
    w_err   = 1'b0;
    w_rd    = 1'b0;
    w_wr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.i_req) begin
          if (!w_legal)                w_next = S_ERR;
          else if (bus.i_size == 2'b11) w_next = S_WRITE;
          else                         w_next = S_READ;
        end
      end
      S_READ: begin
        w_rd   = 1'b1;
        w_next = S_MERGE;
      end
      S_MERGE: w_next = S_WRITE;
      S_WRITE: begin
        w_wr   = 1'b1;
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      S_ERR: begin
        w_done = 1'b1;
        w_err  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch at accept, merged-word register loaded at accept (DW) or in MERGE
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr   <= '0;
      r_size   <= 2'b00;
      r_off    <= 3'b000;
      r_wdata  <= 64'd0;
      r_merged <= 64'd0;
    end else if (r_state == S_IDLE && bus.i_req) begin
      r_addr  <= {bus.i_addr[ADDR_W-1:3], 3'b000};
      r_size  <= bus.i_size;
      r_off   <= bus.i_addr[2:0];
      r_wdata <= bus.i_wdata;
      if (bus.i_size == 2'b11) r_merged <= bus.i_wdata;
    end else if (r_state == S_MERGE) begin
      r_merged <= w_merged;
    end
  end

  assign bus.o_ready              = w_ready;
  assign bus.o_done               = w_done;
  assign bus.o_miss_aligned_error = w_err;
  assign bus.o_dm_rd              = w_rd;
  assign bus.o_dm_wr              = w_wr;
  assign bus.o_dm_addr            = r_addr;
  assign bus.o_dm_wdata           = r_merged;

endmodule

// File: tb/tb_dm_store_controller.sv
// tb/tb_dm_store_controller.sv - directed self-checking bench for dm_store_controller
module tb_dm_store_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dm_store_controller_if #(.ADDR_W(32)) bus();

  dm_store_controller #(.ADDR_W(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Memory returns mem_word only in the cycle after a read strobe, junk otherwise
  logic [63:0] mem_word;
  always @(posedge clk) bus.i_dm_rdata <= bus.o_dm_rd ? mem_word : 64'hA5A5_5A5A_C3C3_3C3C;

  int          rd_cnt, wr_cnt, rd_cyc, done_cyc, err_cyc;
  logic [31:0] rd_addr, wr_addr;
  logic [63:0] wr_data;
  logic        both_seen, ready_busy, ready_after;

  task automatic run_store(input logic [31:0] addr, input logic [1:0] size, input logic [63:0] wdata);
    rd_cnt = 0; wr_cnt = 0; rd_cyc = -1; done_cyc = -1; err_cyc = -1;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    both_seen = 1'b0; ready_busy = 1'b0; ready_after = 1'b0;
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = addr; bus.i_size = size; bus.i_wdata = wdata;
    @(posedge clk);
    #1 bus.i_req = 1'b0;
    for (int k = 1; k <= 8 && done_cyc < 0; k++) begin
      @(negedge clk);
      if (bus.o_dm_rd && bus.o_dm_wr) both_seen = 1'b1;
      if (bus.o_ready) ready_busy = 1'b1;
      if (bus.o_dm_rd) begin rd_cnt++; rd_cyc = k; rd_addr = bus.o_dm_addr; end
      if (bus.o_dm_wr) begin wr_cnt++; wr_addr = bus.o_dm_addr; wr_data = bus.o_dm_wdata; end
      if (bus.o_miss_aligned_error) err_cyc = k;
      if (bus.o_done) done_cyc = k;
    end
    @(negedge clk);
    ready_after = bus.o_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = '0; bus.i_size = 2'b00; bus.i_wdata = '0;
    mem_word = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    tests_run++; if (bus.o_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", bus.o_ready); end
    tests_run++; if (bus.o_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", bus.o_done); end
    tests_run++; if (bus.o_miss_aligned_error !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", bus.o_miss_aligned_error); end
    tests_run++; if ({bus.o_dm_rd, bus.o_dm_wr} !== 2'b00) begin tests_failed++; $display("FAIL reset_rdwr: got %b expected 00", {bus.o_dm_rd, bus.o_dm_wr}); end
    tests_run++; if (bus.o_dm_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr: got %h expected 0", bus.o_dm_addr); end
    tests_run++; if (bus.o_dm_wdata !== 64'h0) begin tests_failed++; $display("FAIL reset_wdata: got %h expected 0", bus.o_dm_wdata); end
  endtask

  task automatic test_partial_byte();
    mem_word = 64'h1122_3344_5566_7788;
    run_store(32'h1003, 2'b00, 64'h0000_0000_0000_00AB);
    tests_run++; if (rd_cnt !== 1) begin tests_failed++; $display("FAIL byte_rd_cnt: got %0d expected 1", rd_cnt); end
    tests_run++; if (rd_cyc !== 1) begin tests_failed++; $display("FAIL byte_rd_cycle: got %0d expected 1", rd_cyc); end
    tests_run++; if (rd_addr !== 32'h1000) begin tests_failed++; $display("FAIL byte_rd_addr: got %h expected 00001000", rd_addr); end
    tests_run++; if (wr_cnt !== 1) begin tests_failed++; $display("FAIL byte_wr_cnt: got %0d expected 1", wr_cnt); end
    tests_run++; if (wr_addr !== 32'h1000) begin tests_failed++; $display("FAIL byte_wr_addr: got %h expected 00001000", wr_addr); end
    tests_run++; if (wr_data !== 64'h1122_3344_AB66_7788) begin tests_failed++; $display("FAIL byte_wr_data: got %h expected 11223344ab667788", wr_data); end
    tests_run++; if (done_cyc !== 3) begin tests_failed++; $display("FAIL byte_done_cycle: got %0d expected 3", done_cyc); end
    tests_run++; if (err_cyc !== -1) begin tests_failed++; $display("FAIL byte_err: got cycle %0d expected none", err_cyc); end
    tests_run++; if (both_seen !== 1'b0) begin tests_failed++; $display("FAIL byte_rd_wr_overlap: got %b expected 0", both_seen); end
    tests_run++; if (ready_busy !== 1'b0) begin tests_failed++; $display("FAIL byte_ready_busy: got %b expected 0", ready_busy); end
    tests_run++; if (ready_after !== 1'b1) begin tests_failed++; $display("FAIL byte_ready_after: got %b expected 1", ready_after); end
  endtask

  task automatic test_partial_sizes();
    logic [31:0] addrs [4] = '{32'h2006, 32'h0004, 32'h0017, 32'h0020};
    logic [1:0]  sizes [4] = '{2'b01, 2'b10, 2'b00, 2'b00};
    logic [63:0] wdats [4] = '{64'hBEEF, 64'hFFFF_FFFF_DEAD_BEEF, 64'h1234_5678_9ABC_DE5A, 64'h77};
    logic [63:0] mems  [4] = '{64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    logic [63:0] exps  [4] = '{64'hBEEF_0000_0000_0000, 64'hDEAD_BEEF_0000_0000, 64'h5AFF_FFFF_FFFF_FFFF, 64'h77};
    logic [31:0] eaddr [4] = '{32'h2000, 32'h0000, 32'h0010, 32'h0020};
    for (int t = 0; t < 4; t++) begin
      mem_word = mems[t];
      run_store(addrs[t], sizes[t], wdats[t]);
      tests_run++; if (wr_data !== exps[t]) begin tests_failed++; $display("FAIL partial%0d_wr_data: got %h expected %h", t, wr_data, exps[t]); end
      tests_run++; if (wr_addr !== eaddr[t] || rd_addr !== eaddr[t]) begin tests_failed++; $display("FAIL partial%0d_addr: got rd %h wr %h expected %h", t, rd_addr, wr_addr, eaddr[t]); end
      tests_run++; if (done_cyc !== 3 || err_cyc !== -1) begin tests_failed++; $display("FAIL partial%0d_done: got done %0d err %0d expected 3 none", t, done_cyc, err_cyc); end
    end
  endtask

  task automatic test_doubleword();
    mem_word = 64'hFFFF_0000_FFFF_0000;
    run_store(32'h0008, 2'b11, 64'h0123_4567_89AB_CDEF);
    tests_run++; if (rd_cnt !== 0) begin tests_failed++; $display("FAIL dw_rd_cnt: got %0d expected 0", rd_cnt); end
    tests_run++; if (wr_cnt !== 1) begin tests_failed++; $display("FAIL dw_wr_cnt: got %0d expected 1", wr_cnt); end
    tests_run++; if (wr_data !== 64'h0123_4567_89AB_CDEF) begin tests_failed++; $display("FAIL dw_wr_data: got %h expected 0123456789abcdef", wr_data); end
    tests_run++; if (wr_addr !== 32'h0008) begin tests_failed++; $display("FAIL dw_wr_addr: got %h expected 00000008", wr_addr); end
    tests_run++; if (done_cyc !== 1 || err_cyc !== -1) begin tests_failed++; $display("FAIL dw_done: got done %0d err %0d expected 1 none", done_cyc, err_cyc); end
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [3] = '{32'h0031, 32'h0042, 32'h0054};
    logic [1:0]  sizes [3] = '{2'b01, 2'b10, 2'b11};
    mem_word = 64'h0;
    for (int t = 0; t < 3; t++) begin
      run_store(addrs[t], sizes[t], 64'hCAFE_F00D_1234_5678);
      tests_run++; if (done_cyc !== 1) begin tests_failed++; $display("FAIL mis%0d_done_cycle: got %0d expected 1", t, done_cyc); end
      tests_run++; if (err_cyc !== 1) begin tests_failed++; $display("FAIL mis%0d_err_cycle: got %0d expected 1", t, err_cyc); end
      tests_run++; if (rd_cnt !== 0 || wr_cnt !== 0) begin tests_failed++; $display("FAIL mis%0d_mem_access: got rd %0d wr %0d expected 0 0", t, rd_cnt, wr_cnt); end
      tests_run++; if (ready_after !== 1'b1) begin tests_failed++; $display("FAIL mis%0d_ready_after: got %b expected 1", t, ready_after); end
    end
  endtask

  task automatic test_reset_mid();
    int wr_seen = 0;
    mem_word = 64'h1122_3344_5566_7788;
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h1003; bus.i_size = 2'b00; bus.i_wdata = 64'hAB;
    @(posedge clk);
    #1 bus.i_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++; if (bus.o_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_ready: got %b expected 1", bus.o_ready); end
    tests_run++; if (bus.o_dm_addr !== 32'h0) begin tests_failed++; $display("FAIL rstmid_addr: got %h expected 0", bus.o_dm_addr); end
    tests_run++; if (bus.o_dm_wdata !== 64'h0) begin tests_failed++; $display("FAIL rstmid_wdata: got %h expected 0", bus.o_dm_wdata); end
    tests_run++; if ({bus.o_dm_rd, bus.o_dm_wr, bus.o_done} !== 3'b000) begin tests_failed++; $display("FAIL rstmid_strobes: got %b expected 000", {bus.o_dm_rd, bus.o_dm_wr, bus.o_done}); end
    repeat (2) begin @(negedge clk); if (bus.o_dm_wr) wr_seen++; end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (bus.o_dm_wr) wr_seen++; end
    tests_run++; if (wr_seen !== 0) begin tests_failed++; $display("FAIL rstmid_no_write: got %0d writes expected 0", wr_seen); end
    tests_run++; if (bus.o_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_ready_after: got %b expected 1", bus.o_ready); end
  endtask

  task automatic test_back_to_back();
    int          first_done = -1, second_done = -1;
    logic        ready_mid = 1'b0;
    logic [63:0] first_data = '0, second_data = '0;
    logic [31:0] second_addr = '0;
    mem_word = 64'h0;
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h1003; bus.i_size = 2'b00; bus.i_wdata = 64'hCD;
    @(posedge clk);
    for (int k = 1; k <= 8 && second_done < 0; k++) begin
      @(negedge clk);
      if (first_done < 0) begin
        if (bus.o_done) begin
          first_done = k; first_data = bus.o_dm_wdata;
          bus.i_addr = 32'h0018; bus.i_size = 2'b11; bus.i_wdata = 64'hFEDC_BA98_7654_3210;
        end
      end else if (k == first_done + 1) begin
        ready_mid = bus.o_ready;
      end else if (bus.o_done) begin
        second_done = k; second_data = bus.o_dm_wdata; second_addr = bus.o_dm_addr;
        bus.i_req = 1'b0;
      end
    end
    bus.i_req = 1'b0;
    tests_run++; if (first_done !== 3) begin tests_failed++; $display("FAIL b2b_first_done: got %0d expected 3", first_done); end
    tests_run++; if (first_data !== 64'h0000_0000_CD00_0000) begin tests_failed++; $display("FAIL b2b_first_data: got %h expected 00000000cd000000", first_data); end
    tests_run++; if (ready_mid !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready_between: got %b expected 1", ready_mid); end
    tests_run++; if (second_done !== 5) begin tests_failed++; $display("FAIL b2b_second_done: got %0d expected 5", second_done); end
    tests_run++; if (second_data !== 64'hFEDC_BA98_7654_3210) begin tests_failed++; $display("FAIL b2b_second_data: got %h expected fedcba9876543210", second_data); end
    tests_run++; if (second_addr !== 32'h0018) begin tests_failed++; $display("FAIL b2b_second_addr: got %h expected 00000018", second_addr); end
  endtask

  initial begin
    test_reset();
    test_partial_byte();
    test_partial_sizes();
    test_doubleword();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
